irom_bank: RTL
==============

// Module: irom_bank
// PURPOSE
//  Instruction ROM feeding the shared instruction-memory controller: single synchronous read port driven by rEN/PC_OUT, returns INS.
//  Adds a byte-serial loader so the program image is written from the host link (UART RX) after reset, before cores start.
//  Reads are blocked while a load is in progress; cores are held via prog_ready=0.
// PARAMETERS
//  WIDTH   8    instruction word width in bits (multiple of 8)
//  DEPTH   256  number of instruction words
//  ADDR_W  8    address width, must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  Clk         in   1       system clock, all logic on rising edge
//  Rst         in   1       synchronous reset, active-high
//  rEN         in   1       read enable from instruction-memory controller
//  PC_IN       in   ADDR_W  read address
//  INS         out  WIDTH   read data
//  ld_start    in   1       one-cycle pulse: begin new program load
//  ld_valid    in   1       ld_data holds a byte
//  ld_data     in   8       load byte stream
//  ld_ready    out  1       loader accepts a byte this cycle (transfer = ld_valid & ld_ready)
//  ld_err      out  1       sticky: length overflow (or checksum fail), cleared by ld_start/Rst
//  prog_ready  out  1       image loaded, reads enabled
// BEHAVIOUR
//  Reset: INS=0, ld_ready=0, ld_err=0, prog_ready=0, FSM=IDLE; memory contents NOT cleared.
//  Read: rising edge with rEN=1 & prog_ready=1 -> INS <= mem[PC_IN]; 1-cycle latency; INS holds otherwise.
//   PC_IN >= DEPTH -> INS <= 0. rEN while prog_ready=0 ignored, INS holds.
//  Loader stream: LEN_LO, LEN_HI (word count L, 16 bit), then L words, each WIDTH/8 bytes little-endian.
//  FSM: IDLE -(ld_start)-> LEN_LO -(byte)-> LEN_HI -(byte)-> DATA (L>0) or DONE (L=0)
//       DATA -(last byte of word L)-> DONE; DONE -> IDLE next cycle, sets prog_ready=1.
//  ld_ready=1 in LEN_LO/LEN_HI/DATA, else 0. ld_start clears prog_ready and ld_err, resets word/byte counters.
//  ld_start in any non-IDLE state restarts at LEN_LO; the byte in that cycle is dropped.
//  Word write: after final byte of a word, mem[wr_addr] <= assembled word, wr_addr++ (next cycle visible to reads).
//  L > DEPTH: ld_err=1, words beyond DEPTH-1 consumed and discarded (no wrap), load still completes, prog_ready=1.
//  Rst mid-load: FSM to IDLE, partial image stays in memory, prog_ready=0 until a full load completes.
//  ld_valid=0 mid-word: assembler holds partial word indefinitely; no timeout.
// CONFIGURATION
//  IROM_CHECKSUM_EN defined: one extra byte after last word (also after L=0); state CSUM between DATA and DONE.
//   Required: 8-bit wrapping sum of all data bytes + checksum byte == 8'h00; else ld_err=1. prog_ready=1 regardless.
//  Undefined: no CSUM state; stream ends at last data byte.
// STRUCTURE
//  Package irom_pkg: loader state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE), LEN_W=16, BYTES_PER_WORD=WIDTH/8.
//  Sub-module irom_byte_assembler: shifts bytes into WIDTH-bit word, byte counter, word_valid pulse on completion.
//  Top holds FSM, word counter, memory array, read register.
// TESTING
//  Rst; load L=3 words 8'hA1,8'hB2,8'hC3 (WIDTH=8) -> prog_ready=1 after 5 accepted bytes +1 cycle; rEN PC=1 -> INS=8'hB2 next edge.
//  WIDTH=16, bytes 01 00 34 12 -> mem[0]=16'h1234; read PC=0 -> INS=16'h1234.
//  L=0 -> DONE directly, prog_ready=1, ld_err=0; memory unchanged from prior load.
//  DEPTH=4, L=6 -> ld_err=1, mem[0..3] written, last 2 words discarded, prog_ready=1, PC=5 read -> INS=0.
//  Rst after 2 data bytes, then rEN=1 -> INS holds 0, prog_ready=0; new ld_start reload succeeds.
//  IROM_CHECKSUM_EN: L=1 data 8'h10 csum 8'hF0 -> ld_err=0; csum 8'hF1 -> ld_err=1.

Source files
------------

// File: rtl/irom_pkg.sv
// Shared types for the instruction ROM bank: loader states, length width, word geometry helper.
package irom_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5
    } ld_state_e;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/irom_byte_assembler.sv
// Packs a little-endian byte stream into WIDTH-bit words; word_vld pulses combinationally with the final byte.
// Latency: 0 cycles from final byte to word_vld. Backpressure: none, holds a partial word while byte_vld is low.
// clr drops any partial word and restarts at byte 0.
module irom_byte_assembler
    import irom_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             byte_vld,
    input  logic [7:0]       byte_dat,
    output logic             word_vld,
    output logic [WIDTH-1:0] word_dat
);

    localparam int BPW = bytes_per_word(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH+7:0] cat;

    always_comb begin
        // New byte enters at the top; earlier bytes drift toward bit 0.
        cat      = {byte_dat, sr_q};
        word_dat = cat[WIDTH+7:8];
        word_vld = byte_vld && (cnt_q == 8'(BPW - 1));
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (byte_vld) begin
            sr_d  = word_dat;
            cnt_d = word_vld ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sr_q  <= '0;
            cnt_q <= 8'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/irom_bank.sv
// Instruction ROM with byte-serial program loader; optional trailing checksum byte under IROM_CHECKSUM_EN.
// Latency: reads 1 cycle (rEN -> INS); prog_ready rises 1 cycle after the final accepted load byte.
// Backpressure: ld_ready low outside load states; reads are ignored until prog_ready.
module irom_bank
    import irom_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              rEN,
    input  logic [ADDR_W-1:0] PC_IN,
    output logic [WIDTH-1:0]  INS,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_err,
    output logic              prog_ready
);

    localparam int               MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W:0]   DEPTH_L = (LEN_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
`ifdef IROM_CHECKSUM_EN
    localparam ld_state_e        TAIL_ST = CSUM;
`else
    localparam ld_state_e        TAIL_ST = DONE;
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    ld_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             err_q, err_d;
    logic             prog_ready_q, prog_ready_d;
    logic             ld_ready_q, ld_ready_d;
    logic [WIDTH-1:0] ins_q, ins_d;
`ifdef IROM_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             xfer;
    logic             data_vld;
    logic             word_vld;
    logic [WIDTH-1:0] word_dat;
    logic             mem_we;

    // A start pulse wins over any byte presented in the same cycle.
    assign xfer     = ld_valid && ld_ready_q && !ld_start;
    assign data_vld = xfer && (state_q == DATA);
    assign mem_we   = word_vld && ({1'b0, words_q} < DEPTH_L);

    irom_byte_assembler #(.WIDTH(WIDTH)) u_asm (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr      (ld_start),
        .byte_vld (data_vld),
        .byte_dat (ld_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        words_d      = words_q;
        err_d        = err_q;
        prog_ready_d = prog_ready_q;
`ifdef IROM_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (ld_start) begin
            state_d      = LEN_LO;
            words_d      = '0;
            err_d        = 1'b0;
            prog_ready_d = 1'b0;
`ifdef IROM_CHECKSUM_EN
            csum_d       = 8'd0;
`endif
        end else begin
            case (state_q)
                LEN_LO: if (xfer) begin
                    len_d[7:0] = ld_data;
                    state_d    = LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    len_d[15:8] = ld_data;
                    if ({1'b0, ld_data, len_q[7:0]} > DEPTH_L) err_d = 1'b1;
                    state_d = ({ld_data, len_q[7:0]} == '0) ? TAIL_ST : DATA;
                end
                DATA: if (xfer) begin
`ifdef IROM_CHECKSUM_EN
                    csum_d = csum_q + ld_data;
`endif
                    if (word_vld) begin
                        words_d = words_q + 1'b1;
                        if (words_q == len_q - 1'b1) state_d = TAIL_ST;
                    end
                end
`ifdef IROM_CHECKSUM_EN
                CSUM: if (xfer) begin
                    if (8'(csum_q + ld_data) != 8'd0) err_d = 1'b1;
                    state_d = DONE;
                end
`endif
                DONE: begin
                    state_d      = IDLE;
                    prog_ready_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        ld_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == CSUM);

        ins_d = ins_q;
        if (rEN && prog_ready_q) begin
            ins_d = ({1'b0, PC_IN} < DEPTH_A) ? mem[PC_IN[MEM_AW-1:0]] : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            words_q      <= '0;
            err_q        <= 1'b0;
            prog_ready_q <= 1'b0;
            ld_ready_q   <= 1'b0;
            ins_q        <= '0;
`ifdef IROM_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_q      <= words_d;
            err_q        <= err_d;
            prog_ready_q <= prog_ready_d;
            ld_ready_q   <= ld_ready_d;
            ins_q        <= ins_d;
`ifdef IROM_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Program storage survives reset so a partial image stays visible.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[words_q[MEM_AW-1:0]] <= word_dat;
    end

    assign INS        = ins_q;
    assign ld_ready   = ld_ready_q;
    assign ld_err     = err_q;
    assign prog_ready = prog_ready_q;

endmodule
